// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer
// with combinational control decode and a retired-instruction counter.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opCode,
    input  logic [5:0]  func,
    input  logic        zero,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [1:0]  RegDst,
    output logic        ALUSrc,
    output logic [2:0]  ALUOp,
    output logic        ExtOp,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  NPCSel,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic [31:0] instr_cnt
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_RCAL, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL
    } class_t;

    state_t      r_state;
    logic [31:0] r_instr_cnt;

    class_t      w_class;
    state_t      w_next;
    logic        w_pcwrite, w_irwrite, w_regwrite, w_memwrite, w_done;

    always_comb begin
        w_class = C_NOP;
        case (opCode)
            6'b000000: begin
                if (func == 6'b100001 || func == 6'b100011) w_class = C_RCAL;
                else if (func == 6'b001000)                 w_class = C_JR;
            end
            6'b001101: w_class = C_ORI;
            6'b001111: w_class = C_LUI;
            6'b100011: w_class = C_LW;
            6'b101011: w_class = C_SW;
            6'b000100: w_class = C_BEQ;
            6'b000010: w_class = C_J;
            6'b000011: w_class = C_JAL;
            default:   w_class = C_NOP;
        endcase
    end

    always_comb begin
        w_next     = FETCH;
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_done     = 1'b0;
        RegDst     = 2'b00;
        ALUSrc     = 1'b0;
        ALUOp      = 3'b000;
        ExtOp      = 1'b0;
        MemtoReg   = 2'b00;
        NPCSel     = 2'b00;
        case (r_state)
            FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                w_next    = DECODE;
            end
            DECODE: begin
                case (w_class)
                    C_J: begin
                        w_pcwrite = 1'b1;
                        NPCSel    = 2'b10;
                    end
                    C_JAL: begin
                        w_pcwrite  = 1'b1;
                        NPCSel     = 2'b10;
                        w_regwrite = 1'b1;
                        RegDst     = 2'b10;
                        MemtoReg   = 2'b10;
                    end
                    C_JR: begin
                        w_pcwrite = 1'b1;
                        NPCSel    = 2'b11;
                    end
                    default: ;
                endcase
                if (w_class == C_J || w_class == C_JAL || w_class == C_JR || w_class == C_NOP)
                    w_next = FETCH;
                else
                    w_next = EXEC;
                w_done = (w_next == FETCH);
            end
            EXEC: begin
                case (w_class)
                    C_RCAL: begin
                        ALUOp  = (func == 6'b100011) ? 3'b001 : 3'b000;
                        w_next = WB;
                    end
                    C_ORI: begin
                        ALUSrc = 1'b1;
                        ALUOp  = 3'b010;
                        w_next = WB;
                    end
                    C_LUI: begin
                        ALUSrc = 1'b1;
                        ALUOp  = 3'b011;
                        w_next = WB;
                    end
                    C_LW, C_SW: begin
                        ALUSrc = 1'b1;
                        ExtOp  = 1'b1;
                        w_next = MEM;
                    end
                    C_BEQ: begin
                        ALUOp     = 3'b001;
                        NPCSel    = 2'b01;
                        w_pcwrite = zero;
                    end
                    default: ;
                endcase
                w_done = (w_next == FETCH);
            end
            MEM: begin
                if (w_class == C_SW) w_memwrite = 1'b1;
                if (w_class == C_LW) w_next = WB;
                w_done = (w_next == FETCH);
            end
            WB: begin
                case (w_class)
                    C_RCAL: begin
                        w_regwrite = 1'b1;
                        RegDst     = 2'b01;
                    end
                    C_ORI, C_LUI: w_regwrite = 1'b1;
                    C_LW: begin
                        w_regwrite = 1'b1;
                        MemtoReg   = 2'b01;
                    end
                    default: ;
                endcase
                w_done = 1'b1;
            end
            // Unused encodings recover to FETCH silently and are not counted.
            default: w_next = FETCH;
        endcase
    end

    assign PCWrite    = w_pcwrite  & ~reset;
    assign IRWrite    = w_irwrite  & ~reset;
    assign RegWrite   = w_regwrite & ~reset;
    assign MemWrite   = w_memwrite & ~reset;
    assign instr_done = w_done     & ~reset;
    assign state      = r_state;
    assign instr_cnt  = r_instr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= FETCH;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_done) r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

endmodule
